// File: rtl/spi_master_sequencer_pkg.sv
// Shared types and sizing helpers for the SPI master sequencer and its command queue.
package spi_master_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to count 0 .. limit-1, never less than one.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/spi_master_sequencer_cmd_fifo.sv
// Synchronous command queue; accepts a push while full only when a pop frees the slot.
module spi_master_sequencer_cmd_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spi_master_sequencer.sv
// Handshaked, timeout-guarded transaction scheduler in front of spi_master_driver.
import spi_master_sequencer_pkg::*;

module spi_master_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int START_WAIT     = 4,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  drv_start,
  output logic [DATA_WIDTH-1:0] drv_data_in,
  input  logic [DATA_WIDTH-1:0] drv_data_out,
  input  logic                  drv_ready
);

  localparam int CNT_LIMIT = max3(GAP_CYCLES, START_WAIT, TIMEOUT_CYCLES);
  localparam int CNT_W     = cnt_width(CNT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_LIMIT - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_WAIT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam seq_state_t       AFTER_TXN    = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  drv_start_q, drv_start_d;
  logic [DATA_WIDTH-1:0] drv_data_in_q, drv_data_in_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  err_q, err_d;

  logic                        fifo_push;
  logic                        fifo_pop;
  logic [DATA_WIDTH-1:0]       fifo_head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  // Only a handshaked word enters the queue, so a stalled host never duplicates.
  assign fifo_push = req_valid && !fifo_full;

  spi_master_sequencer_cmd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (req_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drv_start_d   = 1'b0;
    drv_data_in_d = drv_data_in_q;
    resp_valid_d  = 1'b0;
    resp_data_d   = resp_data_q;
    err_d         = err_q;
    fifo_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && drv_ready) begin
          fifo_pop      = 1'b1;
          drv_data_in_d = fifo_head;
          state_d       = ST_LOAD;
        end
      end
      ST_LOAD: begin
        drv_start_d = 1'b1;
        state_d     = ST_START;
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!drv_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == START_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = AFTER_TXN;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_WAIT_DONE: begin
        if (drv_ready) begin
          resp_data_d  = drv_data_out;
          resp_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = AFTER_TXN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = AFTER_TXN;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      drv_start_q   <= 1'b0;
      drv_data_in_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drv_start_q   <= drv_start_d;
      drv_data_in_q <= drv_data_in_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      err_q         <= err_d;
    end
  end

  assign req_ready   = !fifo_full;
  assign busy        = (state_q != ST_IDLE) || (fifo_count != '0);
  assign err_timeout = err_q;
  assign drv_start   = drv_start_q;
  assign drv_data_in = drv_data_in_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed + randomized bench: a behavioural driver stub and a request/response scoreboard.
module tb_spi_master_sequencer;

  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int GAP     = 8;
  localparam int SWAIT   = 4;
  localparam int TIMEOUT = 512;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [DW-1:0] req_data;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          busy;
  logic          err_timeout;
  logic          drv_start;
  logic [DW-1:0] drv_data_in;
  logic [DW-1:0] drv_data_out;
  logic          drv_ready;

  spi_master_sequencer #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP),
    .START_WAIT     (SWAIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .drv_start    (drv_start),
    .drv_data_in  (drv_data_in),
    .drv_data_out (drv_data_out),
    .drv_ready    (drv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] acc_q [$];
  logic [DW-1:0] exp_q [$];
  int n_checks   = 0;
  int n_fail     = 0;
  int n_starts   = 0;
  int n_resps    = 0;
  int last_start = 0;
  int last_resp  = 0;
  int last_rise  = -1000;
  int fault_next = 0;
  int len_force  = 0;
  int epoch      = 0;
  int full_seen  = 0;

  function automatic logic [DW-1:0] reply(input logic [DW-1:0] w);
    return {w[15:0], w[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver stub: idle-high ready, drops after start, raises with the slave reply.
  initial begin : stub
    logic [DW-1:0] w;
    int mode, len, my_epoch;
    drv_ready    = 1'b1;
    drv_data_out = '0;
    forever begin
      @(negedge clk);
      if (drv_start === 1'b1 && rst === 1'b1) begin
        n_starts++;
        last_start = cyc;
        my_epoch   = epoch;
        check("start_gap", ((cyc - last_rise) >= GAP), 1);
        if (acc_q.size() == 0) begin
          check("start_has_request", drv_start, 0);
          w = '0;
        end else begin
          w = acc_q.pop_front();
          check("drv_data_in", drv_data_in, w);
        end
        mode       = fault_next;
        fault_next = 0;
        if (mode == 0) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          drv_ready = 1'b0;
          len = (len_force > 0) ? len_force : int'($urandom_range(3, 12));
          repeat (len) @(negedge clk);
          drv_data_out = reply(w);
          if (my_epoch == epoch) exp_q.push_back(reply(w));
          drv_ready = 1'b1;
          last_rise = cyc;
        end else if (mode == 2) begin
          drv_ready = 1'b0;
          repeat (600) @(negedge clk);
          drv_ready = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        n_resps++;
        last_resp = cyc;
        if (exp_q.size() == 0) check("resp_unexpected", resp_valid, 0);
        else check("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [DW-1:0] w, output int acc_cyc);
    bit ok;
    int t;
    ok = 1'b0;
    t = 0;
    acc_cyc = 0;
    req_data  = w;
    req_valid = 1'b1;
    while (!ok && t < 400) begin
      ok = (req_ready === 1'b1);
      if (!ok) full_seen++;
      acc_cyc = cyc;
      @(negedge clk);
      t++;
    end
    req_valid = 1'b0;
    if (ok) acc_q.push_back(w);
    check("req_accepted", ok, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t;
    t = 0;
    while (!(busy === 1'b0 && drv_ready === 1'b1) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int t;
    t = 0;
    while (n_starts < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("start_seen", (n_starts >= target), 1);
  endtask

  initial begin : main
    int ca, s0, r0, t, ks;
    logic [DW-1:0] w;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_err", err_timeout, 0);
    check("rst_drv_start", drv_start, 0);
    check("rst_drv_data_in", drv_data_in, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single word: start latency and idle gap.
    s0 = n_starts; r0 = n_resps;
    send(32'hA1A2_A3A4, ca);
    wait_starts(s0 + 1, 50);
    check("t1_latency", last_start - ca, 3);
    t = 0;
    while (n_resps == r0 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    check("t1_busy_drop", cyc - last_resp, GAP);
    wait_idle("t1_idle", 100);
    check("t1_starts", n_starts - s0, 1);
    check("t1_resps", n_resps - r0, 1);

    // Burst of five back-to-back words.
    s0 = n_starts; r0 = n_resps;
    send(32'hA1A2_A3A4, ca);
    send(32'hB1B2_B3B4, ca);
    send(32'hC1C2_C3C4, ca);
    send(32'hD1D2_D3D4, ca);
    send(32'hE1E2_E3E4, ca);
    check("t2_full_ready", req_ready, 0);
    wait_idle("t2_idle", 1000);
    check("t2_resps", n_resps - r0, 5);
    check("t2_exp_drained", exp_q.size(), 0);

    // Random words saturating the queue.
    s0 = n_starts; r0 = n_resps; full_seen = 0;
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      send(w, ca);
    end
    check("t6_backpressure", (full_seen > 0), 1);
    wait_idle("t6_idle", 2000);
    check("t6_starts", n_starts - s0, 10);
    check("t6_resps", n_resps - r0, 10);
    check("t6_acc_drained", acc_q.size(), 0);

    // Ready never drops: start-ack abort, next word still runs.
    s0 = n_starts; r0 = n_resps;
    check("t3_err_before", err_timeout, 0);
    fault_next = 1;
    send($urandom, ca);
    send($urandom, ca);
    wait_starts(s0 + 1, 50);
    ks = last_start;
    t = 0;
    while (err_timeout !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("t3_abort_time", cyc - ks, SWAIT + 1);
    wait_idle("t3_idle", 500);
    check("t3_err", err_timeout, 1);
    check("t3_starts", n_starts - s0, 2);
    check("t3_resps", n_resps - r0, 1);

    // Reset clears the sticky error.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst2_err", err_timeout, 0);
    check("rst2_req_ready", req_ready, 1);
    @(negedge clk);

    // Ready stuck low: done timeout.
    s0 = n_starts; r0 = n_resps;
    fault_next = 2;
    send($urandom, ca);
    wait_starts(s0 + 1, 50);
    ks = last_start;
    t = 0;
    while (err_timeout !== 1'b1 && t < 700) begin @(negedge clk); t++; end
    check("t4_abort_time", cyc - ks, TIMEOUT + 2);
    t = 0;
    while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    check("t4_idle_time", cyc - ks, TIMEOUT + 2 + GAP);
    wait_idle("t4_idle", 200);
    check("t4_resps", n_resps - r0, 0);
    check("t4_err", err_timeout, 1);

    // Reset mid-transaction with two words queued.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    s0 = n_starts; r0 = n_resps;
    len_force = 60;
    send($urandom, ca);
    send($urandom, ca);
    send($urandom, ca);
    wait_starts(s0 + 1, 50);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    epoch++;
    acc_q.delete();
    exp_q.delete();
    check("t5_req_ready", req_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_resp_valid", resp_valid, 0);
    check("t5_err", err_timeout, 0);
    s0 = n_starts;
    repeat (80) @(negedge clk);
    check("t5_no_start", n_starts - s0, 0);
    check("t5_no_resp", n_resps - r0, 0);
    len_force = 0;
    wait_idle("t5_idle", 200);
    r0 = n_resps;
    send(32'h1234_5678, ca);
    wait_idle("t5_after", 200);
    check("t5_resume_resp", n_resps - r0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
